// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
//   Shared definitions for the MIPS pipeline MEM stage.
//   - EX/MEM (75-bit) and MEM/WB (38-bit) bundle widths and field positions
//   - Packed struct views of both bundles (field order matches bit positions)
//   - FSM state encoding for the MEM stage (IDLE = 1'b0, WAIT = 1'b1)
//   - Counter width able to hold MEM_LATENCY-1 for latencies up to 15
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

    // Bundle widths
    localparam int unsigned EXMEM_W = 75;
    localparam int unsigned MEMWB_W = 38;

    // EX/MEM field positions
    localparam int unsigned EX_ALU_LSB   = 0;
    localparam int unsigned EX_ALU_MSB   = 31;
    localparam int unsigned EX_DATA_LSB  = 32;
    localparam int unsigned EX_DATA_MSB  = 63;
    localparam int unsigned EX_RD_LSB    = 64;
    localparam int unsigned EX_RD_MSB    = 68;
    localparam int unsigned EX_ZERO      = 69;
    localparam int unsigned EX_OVF       = 70;
    localparam int unsigned EX_MEMREAD   = 71;
    localparam int unsigned EX_MEMTOREG  = 72;
    localparam int unsigned EX_MEMWRITE  = 73;
    localparam int unsigned EX_REGWRITE  = 74;

    // MEM/WB field positions
    localparam int unsigned WB_VAL_LSB   = 0;
    localparam int unsigned WB_VAL_MSB   = 31;
    localparam int unsigned WB_RD_LSB    = 32;
    localparam int unsigned WB_RD_MSB    = 36;
    localparam int unsigned WB_REGWRITE  = 37;

    // MEM-stage FSM encoding (kept as plain constants for legacy compatibility)
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Latency counter width: MEM_LATENCY is limited to 1..15
    localparam int unsigned CNT_W = 4;

    // Struct views; declaration order is MSB first so the layout matches the
    // field positions above.
    typedef struct packed {
        logic        regwrite;   // [74]
        logic        memwrite;   // [73]
        logic        memtoreg;   // [72]
        logic        memread;    // [71]
        logic        ovf;        // [70]
        logic        zero;       // [69]
        logic [4:0]  rd;         // [68:64]
        logic [31:0] data;       // [63:32]
        logic [31:0] alu;        // [31:0]
    } exmem_t;

    typedef struct packed {
        logic        regwrite;   // [37]
        logic [4:0]  rd;         // [36:32]
        logic [31:0] value;      // [31:0]
    } memwb_t;

    function automatic memwb_t make_wb(input logic regwrite,
                                       input logic [4:0] rd,
                                       input logic [31:0] value);
        memwb_t wb;
        wb.regwrite = regwrite;
        wb.rd       = rd;
        wb.value    = value;
        return wb;
    endfunction

endpackage

// File: rtl/data_ram.sv
// -----------------------------------------------------------------------------
// data_ram
//   DEPTH_WORDS x 32-bit data memory for the MEM stage.
//   Synchronous write on the rising edge, asynchronous (combinational) read.
//   Contents are not reset.
// Ports
//   clk    in   1        rising-edge clock
//   we     in   1        write enable
//   idx    in   ADDR_W   word index (read and write share it)
//   wdata  in   32       write data
//   rdata  out  32       read data at idx
// -----------------------------------------------------------------------------
module data_ram #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
//   MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM bundle,
//   performs word loads/stores on a local data RAM with a configurable
//   multi-cycle latency, and produces the registered MEM/WB bundle.
//   While a multi-cycle access is in flight, mem_stall tells upstream stages
//   to hold EXMEMReg and the PC.
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous reset, active-low
//   EXMEMReg   in   75   EX/MEM bundle (see mips_pipe_pkg::exmem_t)
//   MEMWBReg   out  38   MEM/WB bundle (see mips_pipe_pkg::memwb_t)
//   mem_stall  out  1    high while a memory op is in flight
//   mem_fault  out  1    one-cycle pulse on misaligned/illegal access
// Configuration
//   OVF_SUPPRESS_EN  when defined, an EX overflow suppresses writeback and
//                    any store, and pulses mem_fault.
// -----------------------------------------------------------------------------
module memory_access_stage
    import mips_pipe_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [EXMEM_W-1:0] EXMEMReg,
    output logic [MEMWB_W-1:0] MEMWBReg,
    output logic               mem_stall,
    output logic               mem_fault
);

    localparam bit SINGLE_CYCLE = (MEM_LATENCY == 1);

    exmem_t ex;
    assign ex = exmem_t'(EXMEMReg);

    // Decode of the incoming op
    logic              is_mem;
    logic              misaligned;
    logic              rw_conflict;
    logic              ovf_block;
    logic              fault_now;
    logic [ADDR_W-1:0] ex_idx;

    assign is_mem      = ex.memread | ex.memwrite;
    assign misaligned  = is_mem & (ex.alu[1:0] != 2'b00);
    assign rw_conflict = ex.memread & ex.memwrite;
`ifdef OVF_SUPPRESS_EN
    assign ovf_block   = ex.ovf;
`else
    assign ovf_block   = 1'b0;
`endif
    assign fault_now   = misaligned | rw_conflict | ovf_block;
    // Upper address bits are dropped, so addresses wrap modulo DEPTH_WORDS.
    assign ex_idx      = ex.alu[ADDR_W+1:2];

    // FSM, latency counter and latched op fields
    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              op_store;
    logic              op_memtoreg;
    logic              op_regwrite;
    logic [4:0]        op_rd;
    logic [31:0]       op_alu;
    logic [31:0]       op_data;
    logic [ADDR_W-1:0] op_idx;

    // RAM interface
    logic              ram_we;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // In WAIT the RAM is driven from the latched op so upstream changes to
    // EXMEMReg cannot disturb it; the commit happens on the completion edge.
    // Write enable is gated by rst_n so a store pending when reset arrives
    // is never committed.
    always_comb begin
        ram_we    = 1'b0;
        ram_idx   = ex_idx;
        ram_wdata = ex.data;
        if (state == ST_WAIT) begin
            ram_idx   = op_idx;
            ram_wdata = op_data;
            ram_we    = rst_n & op_store & (cnt == '0);
        end else if (SINGLE_CYCLE) begin
            ram_we    = rst_n & ex.memwrite & ~fault_now;
        end
    end

    data_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Writeback value selection for both access paths
    logic [31:0] single_val;
    logic [31:0] wait_val;

    assign single_val = ex.memtoreg ? ram_rdata : ex.alu;
    assign wait_val   = op_memtoreg ? ram_rdata : op_alu;

    // The counter is loaded with MEM_LATENCY-1 on acceptance and the op
    // completes on the edge after it reaches zero, i.e. MEM_LATENCY edges
    // after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            MEMWBReg    <= '0;
            mem_stall   <= 1'b0;
            mem_fault   <= 1'b0;
            op_store    <= 1'b0;
            op_memtoreg <= 1'b0;
            op_regwrite <= 1'b0;
            op_rd       <= '0;
            op_alu      <= '0;
            op_data     <= '0;
            op_idx      <= '0;
        end else begin
            mem_fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fault_now) begin
                        MEMWBReg  <= make_wb(1'b0, ex.rd, ex.alu);
                        mem_fault <= 1'b1;
                    end else if (!is_mem) begin
                        MEMWBReg  <= make_wb(ex.regwrite, ex.rd, ex.alu);
                    end else if (SINGLE_CYCLE) begin
                        // Stores never write back a register.
                        MEMWBReg  <= make_wb(ex.regwrite & ex.memread, ex.rd, single_val);
                    end else begin
                        state       <= ST_WAIT;
                        cnt         <= CNT_W'(MEM_LATENCY - 1);
                        mem_stall   <= 1'b1;
                        MEMWBReg    <= '0;
                        op_store    <= ex.memwrite;
                        op_memtoreg <= ex.memtoreg;
                        op_regwrite <= ex.regwrite;
                        op_rd       <= ex.rd;
                        op_alu      <= ex.alu;
                        op_data     <= ex.data;
                        op_idx      <= ex_idx;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state     <= ST_IDLE;
                        mem_stall <= 1'b0;
                        MEMWBReg  <= make_wb(op_regwrite & ~op_store, op_rd, wait_val);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_stall <= 1'b0;
                end
            endcase
        end
    end

    // The zero flag is carried in the bundle but has no role in this stage.
    logic unused_ex_bits;
`ifdef OVF_SUPPRESS_EN
    assign unused_ex_bits = ex.zero;
`else
    assign unused_ex_bits = ^{ex.zero, ex.ovf};
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
//   Directed self-checking bench for memory_access_stage at MEM_LATENCY=2,
//   DEPTH_WORDS=256. Inputs change 1 time unit after a rising edge; outputs
//   are sampled at the same point after each edge.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;

    localparam int unsigned L = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [74:0] exmem;
    logic [37:0] memwb;
    logic        stall;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_access_stage #(
        .DEPTH_WORDS (256),
        .ADDR_W      (8),
        .MEM_LATENCY (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EXMEMReg  (exmem),
        .MEMWBReg  (memwb),
        .mem_stall (stall),
        .mem_fault (fault)
    );

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // {RegWrite, MemWrite, MemToReg, MemRead, overflow, zero, rd, data, alu}
    function automatic logic [74:0] mk(input logic rw, input logic mw, input logic m2r,
                                       input logic mr, input logic ovf, input logic [4:0] rd,
                                       input logic [31:0] data, input logic [31:0] alu);
        return {rw, mw, m2r, mr, ovf, 1'b0, rd, data, alu};
    endfunction

    function automatic logic [37:0] wb(input logic rw, input logic [4:0] rd, input logic [31:0] v);
        return {rw, rd, v};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hold a memory op for its full latency, then present a nop.
    task automatic run_mem(input logic [74:0] op);
        exmem = op;
        repeat (L + 1) tick();
        exmem = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        exmem = '0;
        tick();
        tick();
        check("reset_memwb", memwb, 38'h0);
        check("reset_stall", 38'(stall), 38'h0);
        check("reset_fault", 38'(fault), 38'h0);
        rst_n = 1'b1;

        // ALU-only passthrough
        exmem = mk(1, 0, 0, 0, 0, 5'd17, 32'h0, 32'd165);
        tick();
        check("alu_only", memwb, wb(1, 5'd17, 32'd165));
        check("alu_only_stall", 38'(stall), 38'h0);

        // Store 0xDEADBEEF to 0x10: stall for two cycles, bubble
        exmem = mk(0, 1, 0, 0, 0, 5'd0, 32'hDEADBEEF, 32'h10);
        tick();
        check("sw_stall_c1", 38'(stall), 38'h1);
        check("sw_bubble", 38'(memwb[37]), 38'h0);
        tick();
        check("sw_stall_c2", 38'(stall), 38'h1);
        tick();
        check("sw_stall_drop", 38'(stall), 38'h0);
        check("sw_no_regwrite", 38'(memwb[37]), 38'h0);

        // Back-to-back load from 0x10 into rd 9
        exmem = mk(1, 0, 1, 1, 0, 5'd9, 32'h0, 32'h10);
        tick();
        check("lw_stall_c1", 38'(stall), 38'h1);
        check("lw_bubble", 38'(memwb[37]), 38'h0);
        tick();
        check("lw_stall_c2", 38'(stall), 38'h1);
        tick();
        check("lw_result", memwb, wb(1, 5'd9, 32'hDEADBEEF));
        check("lw_stall_drop", 38'(stall), 38'h0);
        exmem = '0;
        tick();

        // Misaligned load: one-cycle fault, no stall, no writeback
        exmem = mk(1, 0, 1, 1, 0, 5'd3, 32'h0, 32'h13);
        tick();
        check("misal_fault", 38'(fault), 38'h1);
        check("misal_stall", 38'(stall), 38'h0);
        check("misal_regwrite", 38'(memwb[37]), 38'h0);
        exmem = '0;
        tick();
        check("misal_fault_pulse", 38'(fault), 38'h0);

        // Read and write both set: illegal
        exmem = mk(1, 1, 1, 1, 0, 5'd4, 32'h00000BAD, 32'h10);
        tick();
        check("rw_both_fault", 38'(fault), 38'h1);
        check("rw_both_stall", 38'(stall), 38'h0);
        // Misaligned store must not touch RAM
        exmem = mk(0, 1, 0, 0, 0, 5'd0, 32'h00000BAD, 32'h12);
        tick();
        check("misal_sw_fault", 38'(fault), 38'h1);
        exmem = '0;
        tick();
        run_mem(mk(1, 0, 1, 1, 0, 5'd9, 32'h0, 32'h10));
        check("ram_unchanged", memwb, wb(1, 5'd9, 32'hDEADBEEF));

        // Address wrap: 0x400 aliases word 0
        run_mem(mk(0, 1, 0, 0, 0, 5'd0, 32'h55, 32'h400));
        run_mem(mk(1, 0, 1, 1, 0, 5'd2, 32'h0, 32'h0));
        check("wrap_lw", memwb, wb(1, 5'd2, 32'h55));
        // Top word and its alias
        run_mem(mk(0, 1, 0, 0, 0, 5'd0, 32'hA5A5A5A5, 32'h3FC));
        run_mem(mk(1, 0, 1, 1, 0, 5'd31, 32'h0, 32'hFFFFFFFC));
        check("wrap_top", memwb, wb(1, 5'd31, 32'hA5A5A5A5));

        // Load with MemToReg=0 still stalls but writes back the ALU value
        exmem = mk(1, 0, 0, 1, 0, 5'd7, 32'h0, 32'h400);
        tick();
        check("lw_alu_stall", 38'(stall), 38'h1);
        tick();
        tick();
        check("lw_alu_value", memwb, wb(1, 5'd7, 32'h400));
        exmem = '0;
        tick();

        // Reset during WAIT aborts a pending store
        run_mem(mk(0, 1, 0, 0, 0, 5'd0, 32'hCAFE0001, 32'h20));
        exmem = mk(0, 1, 0, 0, 0, 5'd0, 32'h1234, 32'h20);
        tick();
        check("rst_wait_stall", 38'(stall), 38'h1);
        rst_n = 1'b0;
        exmem = '0;
        #1;
        check("rst_async_stall", 38'(stall), 38'h0);
        tick();
        tick();
        check("rst_memwb", memwb, 38'h0);
        check("rst_fault", 38'(fault), 38'h0);
        rst_n = 1'b1;
        run_mem(mk(1, 0, 1, 1, 0, 5'd6, 32'h0, 32'h20));
        check("rst_store_aborted", memwb, wb(1, 5'd6, 32'hCAFE0001));

        // Overflow flag on an ALU op
        exmem = mk(1, 0, 0, 0, 1, 5'd5, 32'h0, 32'd77);
        tick();
`ifdef OVF_SUPPRESS_EN
        check("ovf_regwrite", 38'(memwb[37]), 38'h0);
        check("ovf_fault", 38'(fault), 38'h1);
`else
        check("ovf_ignored", memwb, wb(1, 5'd5, 32'd77));
        check("ovf_no_fault", 38'(fault), 38'h0);
`endif
        exmem = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
